dmvm_core: RTL and testbench

DMVM_CORE -- requirements
Module: dmvm_core

---
 rtl/dmvm_core.sv | 168 ++++++++++++++++
 tb/tb_dmvm_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmvm_core.sv
// ============================================================================
// Module      : dmvm_core
// Description : Attention-score unit. Streams Wh rows from an internal BRAM
//               and computes saturated per-node coefficients per subgraph.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dmvm_core #(
    parameter int A_SIZE          = 32,
    parameter int DATA_WIDTH      = 8,
    parameter int BRAM_ADDR_WIDTH = 32,
    parameter int NUM_OF_NODES    = 168,
    parameter int WH_DEPTH        = 256,
    localparam int HALF_A_SIZE    = A_SIZE / 2,
    localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
    localparam int WH_BRAM_WIDTH  = DATA_WIDTH * HALF_A_SIZE + NUM_NODE_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pe_ready_i,
    input  logic [WH_BRAM_WIDTH-1:0]   WH_BRAM_din,
    input  logic                       WH_BRAM_ena,
    input  logic [BRAM_ADDR_WIDTH-1:0] WH_BRAM_addra,
    input  logic [DATA_WIDTH-1:0]      a_i [A_SIZE],
    output logic [DATA_WIDTH-1:0]      coef_o [NUM_OF_NODES],
    output logic                       dmvm_ready_o
);

    localparam int WH_AW   = $clog2(WH_DEPTH);
    localparam int SCORE_W = 2 * DATA_WIDTH + $clog2(HALF_A_SIZE) + 1;
    localparam logic [DATA_WIDTH-1:0] MAX_VALUE = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [NUM_NODE_WIDTH-1:0] r_addrb;
    logic                      r_enb;
    logic                      r_dv;
    logic [NUM_NODE_WIDTH-1:0] r_daddr;
    logic [NUM_NODE_WIDTH-1:0] r_rem;
    logic [SCORE_W-1:0]        r_src;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_coef [NUM_OF_NODES];

    logic [WH_BRAM_WIDTH-1:0]  r_mem [WH_DEPTH];
    logic [WH_BRAM_WIDTH-1:0]  r_dout;

    logic [SCORE_W-1:0]        w_src;
    logic [SCORE_W-1:0]        w_nb;
    logic [SCORE_W-1:0]        w_base;
    logic [SCORE_W:0]          w_tot;
    logic [DATA_WIDTH-1:0]     w_coef;
    logic [NUM_NODE_WIDTH-1:0] w_num;
    logic                      w_flag;
    logic                      w_last;

    // Wh BRAM: no reset on contents or read register; read-before-write on collision.
    always_ff @(posedge clk) begin
        if (WH_BRAM_ena && (WH_BRAM_addra < BRAM_ADDR_WIDTH'(WH_DEPTH))) begin
            r_mem[WH_BRAM_addra[WH_AW-1:0]] <= WH_BRAM_din;
        end
        if (r_enb) begin
            r_dout <= r_mem[WH_AW'(r_addrb)];
        end
    end

    always_comb begin
        w_src = '0;
        w_nb  = '0;
        for (int k = 0; k < HALF_A_SIZE; k++) begin
            w_src = w_src + SCORE_W'(a_i[k]) *
                    SCORE_W'(r_dout[WH_BRAM_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH]);
            w_nb  = w_nb + SCORE_W'(a_i[HALF_A_SIZE+k]) *
                    SCORE_W'(r_dout[WH_BRAM_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH]);
        end
    end

    // A row seen with no rows left in the current subgraph must be a source row.
    assign w_num  = r_dout[NUM_NODE_WIDTH:1];
    assign w_flag = r_dout[0];
    assign w_last = (r_daddr == NUM_NODE_WIDTH'(NUM_OF_NODES - 1));
    assign w_base = (r_rem == '0) ? w_src : r_src;
    assign w_tot  = {1'b0, w_base} + {1'b0, w_nb};
    assign w_coef = (w_tot > (SCORE_W + 1)'(MAX_VALUE)) ? MAX_VALUE : w_tot[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_addrb <= '0;
            r_enb   <= 1'b0;
            r_dv    <= 1'b0;
            r_daddr <= '0;
            r_rem   <= '0;
            r_src   <= '0;
            r_ready <= 1'b0;
            for (int i = 0; i < NUM_OF_NODES; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            r_dv    <= r_enb;
            r_daddr <= r_addrb;
            case (r_state)
                S_IDLE: begin
                    if (pe_ready_i) begin
                        r_state <= S_RUN;
                        r_addrb <= '0;
                        r_enb   <= 1'b1;
                        r_rem   <= '0;
                        for (int i = 0; i < NUM_OF_NODES; i++) begin
                            r_coef[i] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (r_enb) begin
                        if (r_addrb == NUM_NODE_WIDTH'(NUM_OF_NODES - 1)) begin
                            r_enb <= 1'b0;
                        end else begin
                            r_addrb <= r_addrb + 1'b1;
                        end
                    end
                    if (r_dv) begin
                        if ((r_rem == '0) && (!w_flag || (w_num == '0))) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_enb   <= 1'b0;
                        end else begin
                            if (r_rem == '0) begin
                                r_src <= w_src;
                                r_rem <= w_num - 1'b1;
                            end else begin
                                r_rem <= r_rem - 1'b1;
                            end
                            r_coef[r_daddr] <= w_coef;
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_ready <= 1'b1;
                                r_enb   <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!pe_ready_i) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_enb   <= 1'b0;
                end
            endcase
        end
    end

    assign coef_o       = r_coef;
    assign dmvm_ready_o = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_dmvm_core.sv
// ============================================================================
// Module      : tb_dmvm_core
// Description : Directed bench for dmvm_core with a reference-model scoreboard.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dmvm_core;

    localparam int N   = 168;
    localparam int AS  = 32;
    localparam int HA  = 16;
    localparam int WBW = 8 * HA + 8 + 1;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pe;
    logic [WBW-1:0] din;
    logic           ena;
    logic [31:0]    addra;
    logic [7:0]     a [AS];
    logic [7:0]     coef [N];
    logic           ready;

    logic [WBW-1:0] mm [N];
    int             exp_c [N];
    exp_t           sbq [$];
    int             total = 0;
    int             bad   = 0;
    int             cyc;
    int             c28 [10] = '{80, 128, 176, 224, 255, 80, 128, 176, 224, 80};

    dmvm_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pe_ready_i   (pe),
        .WH_BRAM_din  (din),
        .WH_BRAM_ena  (ena),
        .WH_BRAM_addra(addra),
        .a_i          (a),
        .coef_o       (coef),
        .dmvm_ready_o (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [WBW-1:0] mk_row(input int v, input int num, input bit flag, input bit rnd);
        logic [WBW-1:0] r;
        int             f;
        r = '0;
        for (int k = 0; k < HA; k++) begin
            f = rnd ? int'($urandom_range(0, v)) : v;
            r[WBW-1-k*8 -: 8] = f[7:0];
        end
        r[8:1] = num[7:0];
        r[0]   = flag;
        return r;
    endfunction

    task automatic wr(input int ad, input logic [WBW-1:0] r);
        @(negedge clk);
        ena   = 1'b1;
        addra = ad;
        din   = r;
        mm[ad] = r;
        @(negedge clk);
        ena = 1'b0;
    endtask

    // Independent reference: walk subgraphs and compute saturated scores.
    function automatic void model();
        int idx, num, src, nb, s;
        idx = 0;
        for (int j = 0; j < N; j++) exp_c[j] = 0;
        while (idx < N) begin
            if (!mm[idx][0] || mm[idx][8:1] == 0) break;
            num = int'(mm[idx][8:1]);
            src = 0;
            for (int k = 0; k < HA; k++) src += int'(a[k]) * int'(mm[idx][WBW-1-k*8 -: 8]);
            for (int j = idx; j < idx + num && j < N; j++) begin
                nb = 0;
                for (int k = 0; k < HA; k++) nb += int'(a[HA+k]) * int'(mm[j][WBW-1-k*8 -: 8]);
                s = src + nb;
                exp_c[j] = (s > 255) ? 255 : s;
            end
            idx += num;
        end
    endfunction

    task automatic push_model();
        model();
        for (int j = 0; j < N; j++) sbq.push_back('{j, exp_c[j]});
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("%s coef[%0d]", tag, e.idx), {24'd0, coef[e.idx]}, e.val);
        end
    endtask

    task automatic run_pass(input string tag);
        @(negedge clk);
        pe  = 1'b1;
        cyc = 0;
        while (!ready && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " ready"}, {31'd0, ready}, 1);
    endtask

    task automatic stop_pass();
        @(negedge clk);
        pe = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] coef_or();
        logic [7:0] o;
        o = '0;
        for (int j = 0; j < N; j++) o |= coef[j];
        return {24'd0, o};
    endfunction

    initial begin
        rst_n = 1'b1;
        pe    = 1'b0;
        ena   = 1'b0;
        addra = '0;
        din   = '0;
        for (int i = 0; i < AS; i++) a[i] = '0;
        for (int j = 0; j < N; j++) mm[j] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {31'd0, ready}, 0);
        chk("reset coef", coef_or(), 0);
        @(negedge clk);
        rst_n = 1'b0;

        // Two five-row subgraphs, terminated by an all-zero row.
        for (int i = 0; i < AS; i++) a[i] = (i < HA) ? 8'd2 : 8'd3;
        for (int j = 0; j < 5; j++) wr(j, mk_row(j + 1, (j == 0) ? 5 : 0, j == 0, 1'b0));
        for (int j = 0; j < 5; j++) wr(5 + j, mk_row((j == 4) ? 1 : j + 1, (j == 0) ? 5 : 0, j == 0, 1'b0));
        wr(10, '0);
        repeat (3) @(negedge clk);
        chk("idle no start", {31'd0, ready}, 0);
        push_model();
        run_pass("two_sub");
        for (int j = 0; j < 10; j++) chk($sformatf("const coef[%0d]", j), {24'd0, coef[j]}, c28[j]);
        check_sb("two_sub");

        stop_pass();
        chk("done->idle ready", {31'd0, ready}, 0);
        chk("held coef[4]", {24'd0, coef[4]}, 255);
        push_model();
        run_pass("rerun");
        check_sb("rerun");
        stop_pass();

        // Asynchronous reset in the middle of a pass.
        @(negedge clk);
        pe = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("midrun rst ready", {31'd0, ready}, 0);
        chk("midrun rst coef", coef_or(), 0);
        pe = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("post rst idle", {31'd0, ready}, 0);
        push_model();
        run_pass("after_rst");
        check_sb("after_rst");
        stop_pass();

        // Random data: subgraphs of 3,4,1,2 rows, then num_nodes=0 ends the pass.
        for (int i = 0; i < AS; i++) a[i] = 8'($urandom_range(0, 3));
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      wr(j, mk_row(3, 3, 1'b1, 1'b1));
            else if (j == 3) wr(j, mk_row(3, 4, 1'b1, 1'b1));
            else if (j == 7) wr(j, mk_row(3, 1, 1'b1, 1'b1));
            else if (j == 8) wr(j, mk_row(3, 2, 1'b1, 1'b1));
            else             wr(j, mk_row(3, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b1));
        end
        wr(10, mk_row(3, 0, 1'b1, 1'b1));
        push_model();
        run_pass("random");
        check_sb("random");
        stop_pass();

        // Zero attention vector on the same rows.
        for (int i = 0; i < AS; i++) a[i] = '0;
        run_pass("a_zero");
        chk("a_zero coef", coef_or(), 0);
        stop_pass();

        // Row 0 not a source: immediate completion, nothing written.
        for (int i = 0; i < AS; i++) a[i] = 8'd1;
        wr(0, mk_row(5, 5, 1'b0, 1'b0));
        run_pass("flag0");
        chk("flag0 latency", {31'd0, (cyc <= 4)}, 1);
        chk("flag0 coef", coef_or(), 0);
        stop_pass();

        // One subgraph spanning every row: ends after the last node row.
        for (int i = 0; i < AS; i++) a[i] = 8'($urandom_range(0, 3));
        wr(0, mk_row(3, N, 1'b1, 1'b1));
        for (int j = 1; j < N; j++) wr(j, mk_row(3, 0, 1'b0, 1'b1));
        push_model();
        run_pass("full");
        check_sb("full");
        stop_pass();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
